// File: rtl/memory_master_pkg.sv
// Shared definitions for queued_memory_master: command codes, STATUS bit
// positions and the command-field width.
package memory_master_pkg;

    localparam int unsigned FIELD_WIDTH = 24;
    localparam int unsigned STATUS_COUNT_WIDTH = 8;

    typedef enum logic [7:0] {
        NONE           = 8'd0,
        ADDRESS_LOWER  = 8'd1,
        ADDRESS_UPPER  = 8'd2,
        DATA           = 8'd3,
        MASTER_ID      = 8'd4,
        WRITE          = 8'd5,
        PUSH           = 8'd6,
        READ_DATA      = 8'd7,
        READ_MASTER_ID = 8'd8,
        POP            = 8'd9,
        STATUS         = 8'd10,
        INCREMENT      = 8'd11,
        BURST          = 8'd12,
        CLEAR          = 8'd13
    } command_t;

    localparam int unsigned STATUS_REQ_FULL       = 0;
    localparam int unsigned STATUS_RESP_EMPTY     = 1;
    localparam int unsigned STATUS_BUSY           = 2;
    localparam int unsigned STATUS_OVERFLOW       = 3;
    localparam int unsigned STATUS_UNDERFLOW      = 4;
    localparam int unsigned STATUS_REQ_COUNT_LSB  = 8;
    localparam int unsigned STATUS_RESP_COUNT_LSB = 16;

    // Commands that change state and therefore only fire once per arming.
    function automatic logic has_side_effect(input logic [7:0] command);
        case (command)
            ADDRESS_LOWER, ADDRESS_UPPER, DATA, MASTER_ID, WRITE, PUSH,
            POP, INCREMENT, BURST, CLEAR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/MemoryBus.sv
// Memory bus connecting a master to a slave.
// ms*: master-to-slave request channel (msValid/msTaken handshake).
// sm*: slave-to-master response channel (smValid/smTaken handshake).
interface MemoryBus #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ID_WIDTH      = 8
);
    logic [ADDRESS_WIDTH-1:0] msAddress;
    logic [DATA_WIDTH-1:0]    msData;
    logic [ID_WIDTH-1:0]      msID;
    logic                     msWrite;
    logic                     msValid;
    logic                     msTaken;
    logic [DATA_WIDTH-1:0]    smData;
    logic [ID_WIDTH-1:0]      smID;
    logic                     smValid;
    logic                     smTaken;

    modport Master (
        output msAddress, msData, msID, msWrite, msValid,
        input  msTaken,
        input  smData, smID, smValid,
        output smTaken
    );

    modport Slave (
        input  msAddress, msData, msID, msWrite, msValid,
        output msTaken,
        output smData, smID, smValid,
        input  smTaken
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count.
// Ports: clock, reset (async, active-high), push/wdata, pop/rdata (head,
// zero when empty), full, empty, count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // Acceptance depends only on registered full/empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers, count and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + CNT_WIDTH'(1);
                    full  <= (count == LAST);
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - CNT_WIDTH'(1);
                    full  <= 1'b0;
                    empty <= (count == CNT_WIDTH'(1));
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; empty masks stale contents.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/queued_memory_master.sv
// Register-driven memory bus master with request and response queues.
// Ports: clock, reset (async, active-high); in = {command[7:0], field[23:0]};
// out = combinational readback selected by the command; bus = MemoryBus master.
module queued_memory_master
    import memory_master_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned DEPTH         = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in,
    output logic [31:0] out,
    MemoryBus.Master    bus
);
    localparam int unsigned UPPER_WIDTH = ADDRESS_WIDTH - FIELD_WIDTH;
    localparam int unsigned REQ_WIDTH   = ADDRESS_WIDTH + DATA_WIDTH + ID_WIDTH + 1;
    localparam int unsigned RESP_WIDTH  = DATA_WIDTH + ID_WIDTH;
    localparam int unsigned CNT_WIDTH   = $clog2(DEPTH) + 1;

    logic [7:0]               command;
    logic [FIELD_WIDTH-1:0]   field;
    logic                     execute;

    logic [ADDRESS_WIDTH-1:0] addr, addr_n;
    logic [DATA_WIDTH-1:0]    data, data_n;
    logic [ID_WIDTH-1:0]      id, id_n;
    logic                     write, write_n;
    logic [FIELD_WIDTH-1:0]   step, step_n;
    logic [15:0]              burst_left, burst_left_n, burst_pending;
    logic                     overflow, overflow_n;
    logic                     underflow, underflow_n;
    logic                     armed;
    logic                     busy;

    logic                     req_push, req_pop, req_full, req_empty;
    logic [REQ_WIDTH-1:0]     req_head;
    logic [CNT_WIDTH-1:0]     req_count;
    logic                     resp_push, resp_pop, resp_full, resp_empty;
    logic [RESP_WIDTH-1:0]    resp_head;
    logic [CNT_WIDTH-1:0]     resp_count;
    logic [DATA_WIDTH-1:0]    resp_data;
    logic [ID_WIDTH-1:0]      resp_id;

    assign command = in[31:24];
    assign field   = in[23:0];
    assign busy    = (burst_left != 16'd0);
    // A side-effecting command fires only on its first cycle after NONE.
    assign execute = armed && has_side_effect(command);

    // Command decode, burst sequencing and address auto-increment.
    always_comb begin
        addr_n        = addr;
        data_n        = data;
        id_n          = id;
        write_n       = write;
        step_n        = step;
        overflow_n    = overflow;
        underflow_n   = underflow;
        burst_pending = burst_left;
        req_push      = 1'b0;
        resp_pop      = 1'b0;
        if (execute) begin
            case (command)
                ADDRESS_LOWER: addr_n[FIELD_WIDTH-1:0] = field;
                ADDRESS_UPPER: addr_n[ADDRESS_WIDTH-1:FIELD_WIDTH] = field[UPPER_WIDTH-1:0];
                DATA:          data_n  = field[DATA_WIDTH-1:0];
                MASTER_ID:     id_n    = field[ID_WIDTH-1:0];
                WRITE:         write_n = field[0];
                INCREMENT:     step_n  = field;
                PUSH: begin
                    if (req_full || busy) overflow_n = 1'b1;
                    else                  req_push   = 1'b1;
                end
                BURST: begin
                    if (busy) overflow_n    = 1'b1;
                    else      burst_pending = field[15:0];
                end
                POP: begin
                    if (resp_empty) underflow_n = 1'b1;
                    else            resp_pop    = 1'b1;
                end
                CLEAR: begin
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                end
                default: ;
            endcase
        end
        // Burst entries enqueue from the BURST edge on, stalling while full.
        if (burst_pending != 16'd0 && !req_full) begin
            req_push      = 1'b1;
            burst_pending = burst_pending - 16'd1;
        end
        burst_left_n = burst_pending;
        if (req_push) addr_n = addr + ADDRESS_WIDTH'(step);
    end

    // Staging registers and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            data       <= '0;
            id         <= '0;
            write      <= 1'b0;
            step       <= '0;
            burst_left <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            armed      <= 1'b1;
        end else begin
            addr       <= addr_n;
            data       <= data_n;
            id         <= id_n;
            write      <= write_n;
            step       <= step_n;
            burst_left <= burst_left_n;
            overflow   <= overflow_n;
            underflow  <= underflow_n;
            armed      <= (command == NONE);
        end
    end

    sync_fifo #(.WIDTH(REQ_WIDTH), .DEPTH(DEPTH)) req_fifo (
        .clock (clock),
        .reset (reset),
        .push  (req_push),
        .wdata ({addr, data, id, write}),
        .pop   (req_pop),
        .rdata (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    assign req_pop     = bus.msValid && bus.msTaken;
    assign bus.msValid = !req_empty;
    assign {bus.msAddress, bus.msData, bus.msID, bus.msWrite} = req_head;

    sync_fifo #(.WIDTH(RESP_WIDTH), .DEPTH(DEPTH)) resp_fifo (
        .clock (clock),
        .reset (reset),
        .push  (resp_push),
        .wdata ({bus.smData, bus.smID}),
        .pop   (resp_pop),
        .rdata (resp_head),
        .full  (resp_full),
        .empty (resp_empty),
        .count (resp_count)
    );

    assign bus.smTaken = !resp_full;
    assign resp_push   = bus.smValid && !resp_full;
    assign {resp_data, resp_id} = resp_head;

    // Readback mux.
    always_comb begin
        out = '0;
        case (command)
            READ_DATA:      out = 32'(resp_data);
            READ_MASTER_ID: out = 32'(resp_id);
            STATUS: begin
                out[STATUS_REQ_FULL]   = req_full;
                out[STATUS_RESP_EMPTY] = resp_empty;
                out[STATUS_BUSY]       = busy;
                out[STATUS_OVERFLOW]   = overflow;
                out[STATUS_UNDERFLOW]  = underflow;
                out[STATUS_REQ_COUNT_LSB  +: STATUS_COUNT_WIDTH] = STATUS_COUNT_WIDTH'(req_count);
                out[STATUS_RESP_COUNT_LSB +: STATUS_COUNT_WIDTH] = STATUS_COUNT_WIDTH'(resp_count);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_queued_memory_master.sv
// Directed bench for queued_memory_master: a vector table for the request
// path and burst, plus hand-written sequences for overflow, response queue,
// backpressure and reset-during-burst.
module tb_queued_memory_master;
    import memory_master_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in;
    logic [31:0] out;
    int          checks = 0;
    int          errors = 0;

    MemoryBus #(.ADDRESS_WIDTH(32), .DATA_WIDTH(24), .ID_WIDTH(8)) bus_if ();

    queued_memory_master #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(24), .ID_WIDTH(8), .DEPTH(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .out   (out),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        logic        taken;
        logic        chk;
        logic        valid;
        logic [31:0] addr;
        logic [23:0] data;
        logic [7:0]  id;
        logic        wr;
        logic [31:0] out_exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] w(input logic [7:0] c, input logic [23:0] f);
        return {c, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic stage(input logic [31:0] word);
        vec_t r;
        r = '{word, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 8'h0, 1'b0, 32'h0};
        vecs.push_back(r);
    endtask

    task automatic row(input logic [31:0] word, input logic taken, input logic valid,
                       input logic [31:0] addr, input logic [23:0] data, input logic [7:0] id,
                       input logic wr, input logic [31:0] out_exp);
        vec_t r;
        r = '{word, taken, 1'b1, valid, addr, data, id, wr, out_exp};
        vecs.push_back(r);
    endtask

    initial begin
        reset = 1'b1;
        in = w(NONE, 24'h0);
        bus_if.msTaken = 1'b0;
        bus_if.smValid = 1'b0;
        bus_if.smData  = '0;
        bus_if.smID    = '0;

        // Single PUSH, then BURST 5 with step 4 under backpressure, then drain.
        stage(w(ADDRESS_LOWER, 24'h000010)); stage(w(NONE, 0));
        stage(w(ADDRESS_UPPER, 24'h12));     stage(w(NONE, 0));
        stage(w(DATA, 24'hABCDEF));          stage(w(NONE, 0));
        stage(w(MASTER_ID, 24'h3));          stage(w(NONE, 0));
        stage(w(WRITE, 24'h1));              stage(w(NONE, 0));
        row(w(PUSH, 0),   0, 1, 32'h12000010, 24'hABCDEF, 8'h3, 1, 32'h0);
        row(w(STATUS, 0), 0, 1, 32'h12000010, 24'hABCDEF, 8'h3, 1, 32'h102);
        row(w(STATUS, 0), 1, 0, 32'h0, 24'h0, 8'h0, 0, 32'h002);
        stage(w(NONE, 0));
        stage(w(ADDRESS_UPPER, 24'h0)); stage(w(NONE, 0));
        stage(w(INCREMENT, 24'h4));     stage(w(NONE, 0));
        row(w(BURST, 24'h5), 0, 1, 32'h10, 24'hABCDEF, 8'h3, 1, 32'h0);
        row(w(STATUS, 0), 0, 1, 32'h10, 24'hABCDEF, 8'h3, 1, 32'h206);
        row(w(STATUS, 0), 0, 1, 32'h10, 24'hABCDEF, 8'h3, 1, 32'h306);
        row(w(STATUS, 0), 0, 1, 32'h10, 24'hABCDEF, 8'h3, 1, 32'h406);
        row(w(STATUS, 0), 0, 1, 32'h10, 24'hABCDEF, 8'h3, 1, 32'h502);
        row(w(STATUS, 0), 0, 1, 32'h10, 24'hABCDEF, 8'h3, 1, 32'h502);
        row(w(STATUS, 0), 1, 1, 32'h14, 24'hABCDEF, 8'h3, 1, 32'h402);
        row(w(STATUS, 0), 1, 1, 32'h18, 24'hABCDEF, 8'h3, 1, 32'h302);
        row(w(STATUS, 0), 1, 1, 32'h1C, 24'hABCDEF, 8'h3, 1, 32'h202);
        row(w(STATUS, 0), 1, 1, 32'h20, 24'hABCDEF, 8'h3, 1, 32'h102);
        row(w(STATUS, 0), 1, 0, 32'h0, 24'h0, 8'h0, 0, 32'h002);
        stage(w(NONE, 0));

        // Reset state.
        tick(); tick();
        check("reset msValid", 32'(bus_if.msValid), 32'h0);
        check("reset msAddress", bus_if.msAddress, 32'h0);
        check("reset msData", 32'(bus_if.msData), 32'h0);
        check("reset smTaken", 32'(bus_if.smTaken), 32'h1);
        in = w(STATUS, 0);
        #1;
        check("reset status", out, 32'h002);
        in = w(NONE, 0);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            in = vecs[i].word;
            bus_if.msTaken = vecs[i].taken;
            tick();
            if (vecs[i].chk) begin
                check($sformatf("row%0d msValid", i), 32'(bus_if.msValid), 32'(vecs[i].valid));
                check($sformatf("row%0d msAddress", i), bus_if.msAddress, vecs[i].addr);
                check($sformatf("row%0d msData", i), 32'(bus_if.msData), 32'(vecs[i].data));
                check($sformatf("row%0d msID", i), 32'(bus_if.msID), 32'(vecs[i].id));
                check($sformatf("row%0d msWrite", i), 32'(bus_if.msWrite), 32'(vecs[i].wr));
                check($sformatf("row%0d out", i), out, vecs[i].out_exp);
            end
        end
        bus_if.msTaken = 1'b0;

        // Nine PUSHes into an 8-deep queue: the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            in = w(PUSH, 0); tick();
            in = w(NONE, 0); tick();
        end
        in = w(STATUS, 0);
        #1;
        check("ovf status", out, 32'h80B);
        check("ovf head", bus_if.msAddress, 32'h24);
        bus_if.msTaken = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf drain%0d addr", i), bus_if.msAddress, 32'h24 + 32'(4 * i));
            tick();
        end
        bus_if.msTaken = 1'b0;
        check("ovf ninth absent", 32'(bus_if.msValid), 32'h0);
        in = w(NONE, 0);  tick();
        in = w(CLEAR, 0); tick();
        in = w(STATUS, 0);
        #1;
        check("clear status", out, 32'h002);

        // Three response beats, readback, pops and underflow.
        in = w(READ_DATA, 0);
        bus_if.smValid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus_if.smData = 24'(i);
            bus_if.smID   = 8'(6 + i);
            tick();
            if (i == 1) check("resp first beat", out, 32'h1);
        end
        bus_if.smValid = 1'b0;
        check("resp read1", out, 32'h1);
        in = w(READ_MASTER_ID, 0);
        #1;
        check("resp id1", out, 32'h7);
        in = w(NONE, 0); tick();
        in = w(POP, 0);  tick();
        in = w(NONE, 0); tick();
        in = w(READ_DATA, 0);
        #1;
        check("resp read2", out, 32'h2);
        for (int i = 0; i < 2; i++) begin
            in = w(NONE, 0); tick();
            in = w(POP, 0);  tick();
        end
        in = w(READ_DATA, 0);
        #1;
        check("resp empty read", out, 32'h0);
        in = w(NONE, 0); tick();
        in = w(POP, 0);  tick();
        in = w(STATUS, 0);
        #1;
        check("underflow status", out, 32'h012);
        in = w(NONE, 0);  tick();
        in = w(CLEAR, 0); tick();

        // Fill the response queue, then hold PUSH for five cycles.
        in = w(NONE, 0);
        bus_if.smValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_if.smData = 24'h100 + 24'(i);
            tick();
        end
        check("resp full smTaken", 32'(bus_if.smTaken), 32'h0);
        tick();
        bus_if.smValid = 1'b0;
        in = w(PUSH, 0);
        for (int i = 0; i < 5; i++) tick();
        in = w(STATUS, 0);
        #1;
        check("held push status", out, 32'h080100);
        check("held push msValid", 32'(bus_if.msValid), 32'h1);

        // Reset in the middle of a burst.
        in = w(NONE, 0);        tick();
        in = w(BURST, 24'd20);  tick(); tick(); tick();
        check("pre-reset msValid", 32'(bus_if.msValid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async msValid drop", 32'(bus_if.msValid), 32'h0);
        check("async smTaken", 32'(bus_if.smTaken), 32'h1);
        in = w(STATUS, 0);
        tick();
        check("reset status", out, 32'h002);
        reset = 1'b0;
        in = w(NONE, 0);   tick();
        in = w(STATUS, 0); tick();
        check("post-reset status", out, 32'h002);
        check("post-reset msValid", 32'(bus_if.msValid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
